// File: rtl/stone_ram_arbiter_pkg.sv
// stone_ram_arbiter_pkg: arbiter state/owner encodings and default widths,
// shared with the rope and draw controllers.
package stone_ram_arbiter_pkg;
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
  typedef enum logic {OWN_R0, OWN_R1} arb_owner_t;
  localparam int ARB_ADDR_W = 4;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_LOCK_TIMEOUT = 16;
  function automatic arb_owner_t to_owner(input logic rope);
    return rope ? OWN_R1 : OWN_R0;
  endfunction
endpackage

// File: rtl/arb_lock_timer.sv
// arb_lock_timer: counts cycles spent locked and flags the forced-release cycle.
module arb_lock_timer #(
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int CW = $clog2(LOCK_TIMEOUT) + 1;
  logic [CW-1:0] count;
  always_ff @(posedge clock)
    count <= (!resetn || clear) ? '0 : run ? count + 1'b1 : count;
  assign expired = count == CW'(LOCK_TIMEOUT - 1);
endmodule

// File: rtl/stone_ram_arbiter.sv
// stone_ram_arbiter: single-port stone RAM shared by the draw engine and lockable rope ports.
// Define STONE_ARB_PLAYER2_EN to add rope 1 (r1_*) with round-robin between ropes.
module stone_ram_arbiter
  import stone_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int LOCK_TIMEOUT = ARB_LOCK_TIMEOUT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              draw_req,
  input  logic [ADDR_W-1:0] draw_addr,
  output logic              draw_gnt,
  output logic              draw_rvalid,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
`ifdef STONE_ARB_PLAYER2_EN
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
`endif
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] rdata,
  output logic              lock_err
);
  arb_state_t state;
  arb_owner_t owner;
  logic [1:0] req, we, lock, ign, eff, gnt, rv;
  logic [ADDR_W-1:0] r1a, last_addr;
  logic [DATA_W-1:0] r1d;
  logic ptr, own, locked, sel, rope_go, expired, forced, draw_rv;
`ifdef STONE_ARB_PLAYER2_EN
  assign req = {r1_req, r0_req};
  assign we = {r1_we, r0_we};
  assign lock = {r1_lock, r0_lock};
  assign r1a = r1_addr;
  assign r1d = r1_wdata;
  assign r1_gnt = gnt[1];
  assign r1_rvalid = rv[1] & resetn;
  // ptr names the rope preferred on a tie; the just-granted rope yields next time
  always_ff @(posedge clock)
    ptr <= !resetn ? 1'b0 : rope_go ? ~sel : ptr;
`else
  logic unused_r1;
  assign req = {1'b0, r0_req};
  assign we = {1'b0, r0_we};
  assign lock = {1'b0, r0_lock};
  assign r1a = '0;
  assign r1d = '0;
  assign ptr = 1'b0;
  assign unused_r1 = rv[1];
`endif
  assign locked = state == ARB_LOCKED;
  assign own = owner == OWN_R1;
  // a rope timed out of its lock is deaf until it lets go of rN_lock
  assign eff = req & ~(ign & lock);
  assign sel = locked ? own : (&eff ? ptr : eff[1]);
  assign rope_go = resetn & (locked ? eff[own] : ~draw_req & |eff);
  assign draw_gnt = resetn & ~locked & draw_req;
  assign gnt = rope_go ? (sel ? 2'b10 : 2'b01) : 2'b00;
  assign r0_gnt = gnt[0];
  assign forced = locked & expired & lock[own];
  assign lock_err = resetn & forced;
  assign ram_addr = !resetn ? '0 : draw_gnt ? draw_addr : !rope_go ? last_addr : sel ? r1a : r0_addr;
  assign ram_wdata = sel ? r1d : r0_wdata;
  assign ram_wren = rope_go & we[sel];
  assign rdata = ram_q;
  assign draw_rvalid = draw_rv & resetn;
  assign r0_rvalid = rv[0] & resetn;
  always_ff @(posedge clock)
    if (!resetn) begin
      state <= ARB_IDLE;
      owner <= OWN_R0;
      ign <= '0;
      rv <= '0;
      draw_rv <= 1'b0;
      last_addr <= '0;
    end else begin
      draw_rv <= draw_gnt;
      rv <= gnt & ~we;
      ign <= (ign & lock) | (forced ? (own ? 2'b10 : 2'b01) : 2'b00);
      if (draw_gnt | rope_go) last_addr <= ram_addr;
      if (!locked && rope_go && lock[sel]) begin
        state <= ARB_LOCKED;
        owner <= to_owner(sel);
      end else if (locked && (!lock[own] || expired)) state <= ARB_IDLE;
    end
  arb_lock_timer #(.LOCK_TIMEOUT(LOCK_TIMEOUT)) u_timer (
    .clock(clock),
    .resetn(resetn),
    .clear(~locked & rope_go & lock[sel]),
    .run(locked),
    .expired(expired)
  );
endmodule

// File: tb/tb_stone_ram_arbiter.sv
// tb_stone_ram_arbiter: directed scenarios plus random traffic, checked cycle by cycle
// against a transaction-level reference model and a reference copy of the RAM.
module tb_stone_ram_arbiter;
  localparam int AW = 4, DW = 32, LT = 16;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic resetn, draw_req, draw_gnt, draw_rvalid;
  logic [AW-1:0] draw_addr, r0_addr, r1_addr, ram_addr;
  logic r0_req, r0_we, r0_lock, r0_gnt, r0_rvalid;
  logic r1_req, r1_we, r1_lock, r1_gnt, r1_rvalid;
  logic [DW-1:0] r0_wdata, r1_wdata, ram_wdata, ram_q, rdata;
  logic ram_wren, lock_err;
  logic [DW-1:0] mem [16];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end
  stone_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_TIMEOUT(LT)) dut (
    .clock(clock), .resetn(resetn),
    .draw_req(draw_req), .draw_addr(draw_addr), .draw_gnt(draw_gnt), .draw_rvalid(draw_rvalid),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
`ifdef STONE_ARB_PLAYER2_EN
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
`endif
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q),
    .rdata(rdata), .lock_err(lock_err)
  );
`ifndef STONE_ARB_PLAYER2_EN
  assign r1_gnt = 1'b0;
  assign r1_rvalid = 1'b0;
`endif
  int total = 0, bad = 0, n_err = 0;
  logic [DW-1:0] ref_mem [16];
  bit m_locked, m_rvd, m_rv0, m_rv1;
  bit [1:0] m_ign;
  int m_own, m_n, m_last = 1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_rdata;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  // one clock cycle: predict, check combinational and registered outputs, advance the model
  task automatic cyc();
    bit e_dg, e_err;
    bit [1:0] e_g, eff, lk, rq, wq;
    logic [AW-1:0] e_addr;
    int r;
    lk = {r1_lock, r0_lock};
    rq = {r1_req, r0_req};
    wq = {r1_we, r0_we};
    for (int i = 0; i < 2; i++) eff[i] = rq[i] && !(m_ign[i] && lk[i]);
    e_dg = 0;
    e_g = 0;
    r = -1;
    if (resetn) begin
      if (m_locked) begin
        if (eff[m_own]) r = m_own;
      end else if (draw_req) e_dg = 1;
      else if (eff == 2'b11) r = 1 - m_last;
      else if (eff[0]) r = 0;
      else if (eff[1]) r = 1;
    end
    if (r >= 0) e_g[r] = 1;
    e_err = resetn && m_locked && lk[m_own] && m_n == LT;
    e_addr = !resetn ? '0 : e_dg ? draw_addr : r == 0 ? r0_addr : r == 1 ? r1_addr : m_addr;
    #1;
    chk("draw_gnt", draw_gnt, e_dg);
    chk("r0_gnt", r0_gnt, e_g[0]);
    chk("r1_gnt", r1_gnt, e_g[1]);
    chk("one_gnt", $countones({draw_gnt, r0_gnt, r1_gnt}) <= 1, 1);
    chk("ram_wren", ram_wren, r >= 0 && wq[r]);
    chk("ram_addr", ram_addr, e_addr);
    chk("lock_err", lock_err, e_err);
    chk("draw_rvalid", draw_rvalid, resetn && m_rvd);
    chk("r0_rvalid", r0_rvalid, resetn && m_rv0);
    chk("r1_rvalid", r1_rvalid, resetn && m_rv1);
    if (r >= 0 && wq[r]) chk("ram_wdata", ram_wdata, r == 1 ? r1_wdata : r0_wdata);
    if (resetn && (m_rvd || m_rv0 || m_rv1)) chk("rdata", rdata, m_rdata);
    if (lock_err) n_err++;
    @(posedge clock);
    if (!resetn) begin
      m_locked = 0;
      m_ign = 0;
      m_last = 1;
      m_addr = '0;
      m_rvd = 0;
      m_rv0 = 0;
      m_rv1 = 0;
    end else begin
      m_rvd = e_dg;
      m_rv0 = e_g[0] && !r0_we;
      m_rv1 = e_g[1] && !r1_we;
      if (e_dg || (r >= 0 && !wq[r])) m_rdata = ref_mem[e_addr];
      if (r >= 0 && wq[r]) ref_mem[e_addr] = r == 1 ? r1_wdata : r0_wdata;
      if (e_dg || r >= 0) m_addr = e_addr;
      if (r >= 0) m_last = r;
      for (int i = 0; i < 2; i++) if (!lk[i]) m_ign[i] = 0;
      if (m_locked) begin
        if (!lk[m_own]) m_locked = 0;
        else if (m_n == LT) begin
          m_locked = 0;
          m_ign[m_own] = 1;
        end else m_n++;
      end else if (r >= 0 && lk[r]) begin
        m_locked = 1;
        m_own = r;
        m_n = 1;
      end
    end
    @(negedge clock);
  endtask
  task automatic quiet();
    draw_req = 0;
    r0_req = 0; r0_we = 0; r0_lock = 0;
    r1_req = 0; r1_we = 0; r1_lock = 0;
  endtask
  task automatic rope0(input bit rq, input bit wr, input bit lk, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r0_req = rq; r0_we = wr; r0_lock = lk; r0_addr = a; r0_wdata = d;
  endtask
  initial begin
    quiet();
    draw_addr = '0; r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
    resetn = 0;
    draw_req = 1; r0_req = 1;
    cyc(); cyc();
    resetn = 1;
    quiet();
    for (int i = 0; i < 16; i++) begin
      rope0(1, 1, 0, AW'(i), $urandom);
      cyc();
    end
    quiet(); cyc();
    // draw beats rope in IDLE, rope follows once draw drops
    draw_req = 1; draw_addr = 7; rope0(1, 0, 0, 3, 0);
    cyc();
    draw_req = 0;
    cyc();
    quiet(); cyc();
`ifdef STONE_ARB_PLAYER2_EN
    r0_req = 1; r0_addr = 1; r1_req = 1; r1_addr = 2;
    repeat (4) cyc();
    quiet(); cyc();
`endif
    // locked read-modify-write with draw waiting
    rope0(1, 0, 1, 5, 0); cyc();
    rope0(1, 1, 1, 5, 32'hA5A5_0003); draw_req = 1; draw_addr = 5; cyc();
    rope0(0, 0, 0, 5, 0); cyc();
    cyc();
    draw_req = 0;
    #1 chk("rmw_rdata", rdata, 32'hA5A5_0003);
    cyc();
    quiet(); cyc();
    // lock held past the timeout
    n_err = 0;
    rope0(1, 0, 1, 2, 0); cyc();
    for (int i = 0; i < 20; i++) begin
      rope0(1, 0, 1, 2, 0);
      draw_req = i < 17;
      draw_addr = 1;
      cyc();
    end
    draw_req = 0;
    rope0(1, 0, 0, 2, 0); cyc();
    quiet(); cyc();
    chk("lock_err_count", n_err, 1);
    // reset while locked with a read in flight
    rope0(1, 0, 1, 6, 0); cyc();
    rope0(1, 0, 1, 7, 0); cyc();
    resetn = 0; cyc();
    resetn = 1; quiet();
    r0_req = 1; r0_addr = 8; r1_req = 1; r1_addr = 9;
    cyc();
    quiet(); cyc(); cyc();
    for (int k = 0; k < 3000; k++) begin
      resetn = $urandom_range(99) != 0;
      draw_req = $urandom_range(9) < 3;
      draw_addr = AW'($urandom);
      r0_req = 1'($urandom_range(1));
      r0_we = 1'($urandom_range(1));
      if ($urandom_range(19) == 0) r0_lock = ~r0_lock;
      r0_addr = AW'($urandom);
      r0_wdata = $urandom;
`ifdef STONE_ARB_PLAYER2_EN
      r1_req = 1'($urandom_range(1));
      r1_we = 1'($urandom_range(1));
      if ($urandom_range(19) == 0) r1_lock = ~r1_lock;
      r1_addr = AW'($urandom);
      r1_wdata = $urandom;
`endif
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stone_ram_arbiter.md
STONE_RAM_ARBITER -- requirements
Module: stone_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, stone RAM address width (16 stone records).
REQ-002 Parameter DATA_W, default 32, stone record width.
REQ-003 Parameter LOCK_TIMEOUT, default 16, maximum number of cycles one rope port may hold a lock.
REQ-004 Port list, in order:
- clock  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- draw_req  in  1  read request from the draw engine.
- draw_addr  in  ADDR_W  draw engine read address.
- draw_gnt  out  1  draw request accepted this cycle.
- draw_rvalid  out  1  draw read data valid on rdata.
- rN_req  in  1  rope N request (N = 0, 1).
- rN_we  in  1  rope N write.
- rN_lock  in  1  rope N holds the RAM across cycles.
- rN_addr  in  ADDR_W  rope N address.
- rN_wdata  in  DATA_W  rope N write data.
- rN_gnt  out  1  rope N request accepted this cycle.
- rN_rvalid  out  1  rope N read data valid on rdata.
- ram_addr  out  ADDR_W  address to the single-port RAM.
- ram_wdata  out  DATA_W  write data to the RAM.
- ram_wren  out  1  RAM write enable.
- ram_q  in  DATA_W  RAM read data, one cycle after address.
- rdata  out  DATA_W  ram_q passthrough.
- lock_err  out  1  one-cycle pulse on forced lock release.

Function
REQ-005 Arbitration and the gnt outputs SHALL be combinational from the req inputs and registered arbiter state; at most one gnt SHALL be high per cycle.
REQ-006 In state IDLE, draw_req SHALL win over any rope request.
REQ-007 Without a draw request, ropes SHALL be granted round-robin; the pointer SHALL flip only after a rope grant.
REQ-008 ram_addr, ram_wdata and ram_wren SHALL follow the granted port combinationally; ram_wren = gnt & we; with no grant, ram_wren = 0 and ram_addr holds its last value.
REQ-009 For a granted read in cycle N, the matching rvalid SHALL pulse in cycle N+1, with rdata = ram_q; a granted write SHALL produce no rvalid.
REQ-010 A rope grant with rN_lock = 1 SHALL move the arbiter to LOCKED(owner = N) in cycle N+1 and clear the lock counter.
REQ-011 In LOCKED, only the owner SHALL be granted, and draw_req SHALL stall (draw_gnt = 0).
REQ-012 In LOCKED, the counter SHALL increment each cycle.
REQ-013 LOCKED SHALL return to IDLE on whichever comes first:
- owner rN_lock = 0 (normal release);
- counter reaching LOCK_TIMEOUT - 1 (forced release, lock_err pulses in the same cycle).
REQ-014 On forced release, the owner's rN_req SHALL be ignored until it deasserts rN_lock.
REQ-015 A granted request in the release cycle SHALL complete normally.
REQ-016 Read-modify-write sequence (locked read, then locked write to the same address) SHALL be atomic with respect to all other ports.
REQ-017 A draw_req held during LOCKED SHALL be granted in the first IDLE cycle.

Reset
REQ-018 When resetn = 0 at a clock edge, the block SHALL enter IDLE.
REQ-019 Reset SHALL set the round-robin pointer to rope 0, clear the lock counter and rvalid registers, and drop lock_err.
REQ-020 During reset, all gnt outputs and ram_wren SHALL be 0, ram_addr 0, and rvalid outputs 0.
REQ-021 Reset mid-lock SHALL abandon the lock without a lock_err pulse, and a read in flight SHALL produce no rvalid.

Configuration
REQ-022 With macro STONE_ARB_PLAYER2_EN defined, the r1_* ports SHALL exist and rope round-robin SHALL be active.
REQ-023 Without STONE_ARB_PLAYER2_EN, the r1_* ports SHALL be absent, rope 0 SHALL be the only rope, and the pointer SHALL be removed; all other behaviour is unchanged.

Structure
REQ-024 A shared package SHALL hold the state encoding (ARB_IDLE, ARB_LOCKED), the owner encoding (OWN_R0, OWN_R1), and default ADDR_W/DATA_W constants, for reuse by the rope and draw controllers.
REQ-025 The lock counter and timeout compare SHALL be one sub-module, arb_lock_timer; all other logic is flat.

Verification
REQ-026 draw_req and r0_req (read, addr 3) in the same cycle -> draw_gnt = 1 that cycle; r0_gnt = 1 the next cycle if draw_req drops; each rvalid follows its gnt by one cycle.
REQ-027 r0_req and r1_req held, no draw -> grants alternate r0, r1, r0, r1 over 4 cycles.
REQ-028 Locked RMW: r0 locked read addr 5, then locked write 0xA5A5_0003 to addr 5, while draw_req is held high -> draw_gnt = 0 throughout the lock; draw_gnt = 1 in the cycle after r0_lock drops; the draw read of addr 5 returns 0xA5A5_0003.
REQ-029 r0_lock held 20 cycles, LOCK_TIMEOUT = 16 -> lock_err pulses once in the 16th locked cycle; draw is granted next; r0_req is ignored until r0_lock = 0.
REQ-030 resetn low during LOCKED with a read in flight -> in the next cycle all gnt/rvalid = 0, IDLE, pointer at rope 0, no lock_err.
